// File: rtl/coord_pkg.sv
// Shared types for the cursor/scan controller: coordinate width, FSM states,
// button indices and the saturating coordinate step.
package coord_pkg;

  localparam int COORD_W = 3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;
  localparam int NUM_BTN   = 5;

  // Opposing requests cancel; the bound is tested before the add/subtract,
  // so the 3-bit value never wraps.
  function automatic coord_t step_coord(coord_t cur, logic inc, logic dec, coord_t max_v);
    coord_t nxt;
    nxt = cur;
    if (inc && !dec && (cur != max_v)) begin
      nxt = cur + coord_t'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - coord_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for one debounced button against its registered history.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= d_i;
    end
  end

  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/coord_scan_ctrl.sv
// Cursor position, shot handshake, column scan and blink generation for the
// LED matrix; mdc/mdl drive the existing demux selector directly.
module coord_scan_ctrl
  import coord_pkg::*;
#(
  parameter int MAX_COL   = 4,
  parameter int MAX_LIN   = 6,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_fire,
  input  logic         fire_ack,
  output logic [2:0]   mdc,
  output logic [2:0]   mdl,
  output logic         fire_req,
  output logic [2:0]   fire_col,
  output logic [2:0]   fire_lin,
  output logic [2:0]   scan_col,
  output logic         cursor_blink,
  output logic         busy
);

  localparam coord_t MAX_COL_C = coord_t'(MAX_COL);
  localparam coord_t MAX_LIN_C = coord_t'(MAX_LIN);

  // +1 keeps the width non-zero when a divider is 1.
  localparam int            SCAN_W     = $clog2(SCAN_DIV + 1);
  localparam int            BLINK_W    = $clog2(BLINK_DIV + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [NUM_BTN-1:0] btn_vec;
  logic [NUM_BTN-1:0] rise;

  assign btn_vec = {btn_fire, btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_edge
    edge_det u_edge (
      .clk    (clk),
      .rst    (rst),
      .d_i    (btn_vec[g]),
      .rise_o (rise[g])
    );
  end

  state_e state_q;
  coord_t mdc_q, mdl_q, fire_col_q, fire_lin_q;
  logic   fire_req_q, busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mdc_q      <= '0;
      mdl_q      <= '0;
      fire_col_q <= '0;
      fire_lin_q <= '0;
      fire_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A shot takes priority; move edges in the same cycle are dropped.
          if (rise[BTN_FIRE]) begin
            fire_col_q <= mdc_q;
            fire_lin_q <= mdl_q;
            fire_req_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= WAIT_ACK;
          end else begin
            mdc_q <= step_coord(mdc_q, rise[BTN_RIGHT], rise[BTN_LEFT], MAX_COL_C);
            mdl_q <= step_coord(mdl_q, rise[BTN_UP], rise[BTN_DOWN], MAX_LIN_C);
          end
        end
        WAIT_ACK: begin
          if (fire_ack) begin
            fire_req_q <= 1'b0;
            state_q    <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!fire_ack) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          fire_req_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  coord_t             scan_col_q, scan_col_d;
  logic               blink_q, blink_d;

  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    scan_col_d  = scan_col_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_d     = blink_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_col_d = (scan_col_q == MAX_COL_C) ? '0 : scan_col_q + coord_t'(1);
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      scan_col_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      scan_col_q  <= scan_col_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign mdc          = mdc_q;
  assign mdl          = mdl_q;
  assign fire_req     = fire_req_q;
  assign fire_col     = fire_col_q;
  assign fire_lin     = fire_lin_q;
  assign busy         = busy_q;
  assign scan_col     = scan_col_q;
  assign cursor_blink = blink_q;

endmodule

// File: tb/tb_coord_scan_ctrl.sv
// Self-checking bench for coord_scan_ctrl: directed scenarios plus random
// button/ack traffic against a cycle-level behavioural model.
module tb_coord_scan_ctrl;

  localparam int MAX_COL   = 4;
  localparam int MAX_LIN   = 6;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_fire, fire_ack;
  logic [2:0] mdc, mdl, fire_col, fire_lin, scan_col;
  logic       fire_req, cursor_blink, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  coord_scan_ctrl #(
    .MAX_COL   (MAX_COL),
    .MAX_LIN   (MAX_LIN),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_fire     (btn_fire),
    .fire_ack     (fire_ack),
    .mdc          (mdc),
    .mdl          (mdl),
    .fire_req     (fire_req),
    .fire_col     (fire_col),
    .fire_lin     (fire_lin),
    .scan_col     (scan_col),
    .cursor_blink (cursor_blink),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers, phase 0 = idle, 1 = awaiting ack,
  // 2 = awaiting ack release.
  int       m_col, m_lin, m_fcol, m_flin, m_phase, m_cycles;
  bit       m_req;
  bit [4:0] m_prev;

  function automatic void model_reset();
    m_col = 0; m_lin = 0; m_fcol = 0; m_flin = 0;
    m_phase = 0; m_req = 0; m_prev = '0; m_cycles = 0;
  endfunction

  function automatic void model_step(bit up, bit down, bit left, bit right, bit fire, bit ack);
    bit [4:0] now, e;
    now = {fire, right, left, down, up};
    e = now & ~m_prev;
    m_prev = now;
    m_cycles++;
    if (m_phase == 0) begin
      if (e[4]) begin
        m_fcol = m_col; m_flin = m_lin; m_req = 1; m_phase = 1;
      end else begin
        if (e[0] && !e[1] && m_lin < MAX_LIN) m_lin++;
        if (e[1] && !e[0] && m_lin > 0) m_lin--;
        if (e[3] && !e[2] && m_col < MAX_COL) m_col++;
        if (e[2] && !e[3] && m_col > 0) m_col--;
      end
    end else if (m_phase == 1) begin
      if (ack) begin m_req = 0; m_phase = 2; end
    end else begin
      if (!ack) m_phase = 0;
    end
  endfunction

  function automatic logic [13:0] exp_vec();
    return {3'(m_col), 3'(m_lin), m_req, 3'(m_fcol), 3'(m_flin), (m_phase != 0)};
  endfunction

  function automatic logic [3:0] exp_scan();
    int sc, bl;
    sc = (m_cycles / SCAN_DIV) % (MAX_COL + 1);
    bl = (m_cycles / BLINK_DIV) % 2;
    return {3'(sc), bl[0]};
  endfunction

  task automatic apply(input bit up, input bit down, input bit left, input bit right,
                       input bit fire, input bit ack);
    btn_up = up; btn_down = down; btn_left = left; btn_right = right;
    btn_fire = fire; fire_ack = ack;
    @(posedge clk);
    model_step(up, down, left, right, fire, ack);
    #1;
  endtask

  task automatic do_reset(input bit hold_up);
    rst = 1'b1;
    btn_up = hold_up; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0; fire_ack = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0; fire_ack = 0;
    #2;
    tests_run++;
    if ({mdc, mdl, fire_req, fire_col, fire_lin, busy, scan_col, cursor_blink} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected 0",
               {mdc, mdl, fire_req, fire_col, fire_lin, busy, scan_col, cursor_blink});
    end
    do_reset(1'b0);
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    for (int p = 1; p <= 5; p++) begin
      apply(0, 0, 0, 1, 0, 0);
      apply(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (mdc !== 3'((p < 4) ? p : 4) || mdl !== 3'd0) begin
        tests_failed++;
        $display("FAIL right_saturate pulse=%0d: got mdc=%0d mdl=%0d expected mdc=%0d mdl=0",
                 p, mdc, mdl, (p < 4) ? p : 4);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b0);
    for (int p = 0; p < 3; p++) begin
      apply(1, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0);
    end
    apply(1, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (mdl !== 3'd3) begin
      tests_failed++;
      $display("FAIL up_down_cancel: got mdl=%0d expected 3", mdl);
    end
    do_reset(1'b0);
    apply(1, 0, 0, 1, 0, 0);
    tests_run++;
    if ({mdc, mdl} !== {3'd1, 3'd1}) begin
      tests_failed++;
      $display("FAIL up_right_diag: got (%0d,%0d) expected (1,1)", mdc, mdl);
    end
  endtask

  task automatic test_fire_handshake();
    do_reset(1'b0);
    for (int p = 0; p < 2; p++) begin apply(0, 0, 0, 1, 0, 0); apply(0, 0, 0, 0, 0, 0); end
    for (int p = 0; p < 5; p++) begin apply(1, 0, 0, 0, 0, 0); apply(0, 0, 0, 0, 0, 0); end
    apply(0, 0, 0, 0, 1, 0);
    tests_run++;
    if ({fire_req, fire_col, fire_lin, busy} !== {1'b1, 3'd2, 3'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL fire_latch: got req=%0d col=%0d lin=%0d busy=%0d expected 1,2,5,1",
               fire_req, fire_col, fire_lin, busy);
    end
    apply(0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    tests_run++;
    if (mdc !== 3'd2 || fire_req !== 1'b1 || fire_col !== 3'd2 || fire_lin !== 3'd5) begin
      tests_failed++;
      $display("FAIL wait_ack_ignore: got mdc=%0d req=%0d col=%0d lin=%0d expected 2,1,2,5",
               mdc, fire_req, fire_col, fire_lin);
    end
    apply(0, 0, 0, 0, 0, 1);
    tests_run++;
    if (fire_req !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_clears_req: got req=%0d busy=%0d expected 0,1", fire_req, busy);
    end
    apply(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (busy !== 1'b0 || mdc !== 3'd2) begin
      tests_failed++;
      $display("FAIL ack_release_idle: got busy=%0d mdc=%0d expected 0,2", busy, mdc);
    end
    apply(0, 0, 0, 0, 0, 1);
    tests_run++;
    if (fire_req !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_in_idle: got req=%0d busy=%0d expected 0,0", fire_req, busy);
    end
  endtask

  task automatic test_fire_with_move();
    do_reset(1'b0);
    apply(1, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 1, 0);
    tests_run++;
    if ({fire_req, fire_col, fire_lin, mdc, mdl} !== {1'b1, 3'd1, 3'd1, 3'd1, 3'd1}) begin
      tests_failed++;
      $display("FAIL fire_drops_move: got req=%0d shot=(%0d,%0d) cur=(%0d,%0d) expected 1,(1,1),(1,1)",
               fire_req, fire_col, fire_lin, mdc, mdl);
    end
    apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_scan_blink();
    do_reset(1'b0);
    for (int n = 1; n <= 44; n++) begin
      apply(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (scan_col !== 3'((n / SCAN_DIV) % (MAX_COL + 1)) || cursor_blink !== 1'((n / BLINK_DIV) % 2)) begin
        tests_failed++;
        $display("FAIL scan_blink n=%0d: got scan=%0d blink=%0d expected scan=%0d blink=%0d",
                 n, scan_col, cursor_blink, (n / SCAN_DIV) % (MAX_COL + 1), (n / BLINK_DIV) % 2);
      end
    end
  endtask

  task automatic test_reset_in_wait_ack();
    do_reset(1'b0);
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    tests_run++;
    if (fire_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_req: got %0d expected 1", fire_req);
    end
    btn_fire = 0;
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({mdc, mdl, fire_req, fire_col, fire_lin, busy, scan_col, cursor_blink} !== 18'd0) begin
      tests_failed++;
      $display("FAIL async_reset_wait_ack: got %h expected 0",
               {mdc, mdl, fire_req, fire_col, fire_lin, busy, scan_col, cursor_blink});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    tests_run++;
    if ({fire_req, busy, mdc, mdl} !== 8'd0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got req=%0d busy=%0d cur=(%0d,%0d) expected 0,0,(0,0)",
               fire_req, busy, mdc, mdl);
    end
  endtask

  task automatic test_held_through_reset();
    do_reset(1'b1);
    apply(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (mdl !== 3'd1) begin
      tests_failed++;
      $display("FAIL held_btn_first_edge: got mdl=%0d expected 1", mdl);
    end
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (mdl !== 3'd1) begin
      tests_failed++;
      $display("FAIL held_btn_single_action: got mdl=%0d expected 1", mdl);
    end
  endtask

  task automatic test_random();
    bit up, down, left, right, fire, ack;
    do_reset(1'b0);
    up = 0; down = 0; left = 0; right = 0; fire = 0; ack = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) up    = ~up;
      if ($urandom_range(0, 3) == 0) down  = ~down;
      if ($urandom_range(0, 3) == 0) left  = ~left;
      if ($urandom_range(0, 3) == 0) right = ~right;
      if ($urandom_range(0, 7) == 0) fire  = ~fire;
      if ($urandom_range(0, 2) == 0) ack   = ~ack;
      apply(up, down, left, right, fire, ack);
      tests_run++;
      if ({mdc, mdl, fire_req, fire_col, fire_lin, busy} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_ctrl cyc=%0d: got %h expected %h", n,
                 {mdc, mdl, fire_req, fire_col, fire_lin, busy}, exp_vec());
      end
      tests_run++;
      if ({scan_col, cursor_blink} !== exp_scan()) begin
        tests_failed++;
        $display("FAIL random_scan cyc=%0d: got %h expected %h", n,
                 {scan_col, cursor_blink}, exp_scan());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_saturation();
    test_simultaneous();
    test_fire_handshake();
    test_fire_with_move();
    test_scan_blink();
    test_reset_in_wait_ack();
    test_held_through_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
